// File: rtl/a2d_rr_sched.sv
// Round-robin ADC128S conversion scheduler: left load cell, right load cell, battery.
// Optional battery-low flag enabled by defining BATT_LOW_EN.
module a2d_rr_sched #(
  parameter logic [2:0]  CH_LFT      = 3'd0,
  parameter logic [2:0]  CH_RGHT     = 3'd4,
  parameter logic [2:0]  CH_BATT     = 3'd5,
  parameter int unsigned GAP_CYC     = 2,
  parameter logic [11:0] BATT_THRESH = 12'h800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
`ifdef BATT_LOW_EN
  output logic        batt_low,
`endif
  output logic        busy
);

  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_CMD1, S_WAIT1, S_GAP, S_CMD2, S_WAIT2} state_t;
  typedef enum logic [1:0] {P_LFT, P_RGHT, P_BATT} ptr_t;

  state_t           state_q, state_d;
  ptr_t             ptr_q, ptr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             wrt_q, wrt_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             busy_q, busy_d;
  logic             cnv_q, cnv_d;
  logic [11:0]      lft_q, lft_d;
  logic [11:0]      rght_q, rght_d;
  logic [11:0]      batt_q, batt_d;
  logic [2:0]       ch_sel;
  logic             done_ok;
`ifdef BATT_LOW_EN
  logic             batt_low_q, batt_low_d;
`else
  logic [11:0]      unused_thresh;
  assign unused_thresh = BATT_THRESH;
`endif
  logic [3:0]       unused_rd_hi;
  assign unused_rd_hi = rd_data[15:12];

  // The master needs at least one clk after wrt, so a coincident done is spurious.
  assign done_ok = done & ~wrt_q;

  always_comb begin
    case (ptr_q)
      P_RGHT:  ch_sel = CH_RGHT;
      P_BATT:  ch_sel = CH_BATT;
      default: ch_sel = CH_LFT;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    busy_d  = busy_q;
    cnv_d   = 1'b0;
    lft_d   = lft_q;
    rght_d  = rght_q;
    batt_d  = batt_q;
`ifdef BATT_LOW_EN
    batt_low_d = batt_low_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (nxt) begin
          state_d = S_CMD1;
          cmd_d   = {2'b00, ch_sel, 11'h000};
          busy_d  = 1'b1;
        end
      end
      S_CMD1: begin
        wrt_d   = 1'b1;
        state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (done_ok) begin
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? S_CMD2 : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = S_CMD2;
        else                              gap_d   = gap_q + GAP_W'(1);
      end
      S_CMD2: begin
        wrt_d   = 1'b1;
        state_d = S_WAIT2;
      end
      S_WAIT2: begin
        if (done_ok) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnv_d   = 1'b1;
          case (ptr_q)
            P_RGHT: begin
              rght_d = rd_data[11:0];
              ptr_d  = P_BATT;
            end
            P_BATT: begin
              batt_d = rd_data[11:0];
`ifdef BATT_LOW_EN
              batt_low_d = (rd_data[11:0] < BATT_THRESH);
`endif
              ptr_d  = P_LFT;
            end
            default: begin
              lft_d  = rd_data[11:0];
              ptr_d  = P_RGHT;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= P_LFT;
      gap_q   <= '0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      busy_q  <= 1'b0;
      cnv_q   <= 1'b0;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      batt_q  <= 12'h000;
`ifdef BATT_LOW_EN
      batt_low_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      cnv_q   <= cnv_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      batt_q  <= batt_d;
`ifdef BATT_LOW_EN
      batt_low_q <= batt_low_d;
`endif
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign busy      = busy_q;
  assign cnv_cmplt = cnv_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign batt      = batt_q;
`ifdef BATT_LOW_EN
  assign batt_low  = batt_low_q;
`endif

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Bench for a2d_rr_sched: transaction-level reference model, scoreboard queues, SPI responder.
module tb_a2d_rr_sched;

  localparam int unsigned TB_GAP = 3;
  localparam logic [11:0] THRESH = 12'h800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, nxt, done;
  logic [15:0] rd_data;
  logic        wrt, cnv_cmplt, busy;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        nxt0, done0;
  logic [15:0] rd_data0;
  logic        wrt0, cnv0, busy0;
  logic [15:0] cmd0;
  logic [11:0] lft0, rght0, batt0;
`ifdef BATT_LOW_EN
  logic        batt_low, batt_low0;
`endif

  a2d_rr_sched #(.GAP_CYC(TB_GAP), .BATT_THRESH(THRESH)) u_dut (
    .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt), .cnv_cmplt(cnv_cmplt),
`ifdef BATT_LOW_EN
    .batt_low(batt_low),
`endif
    .busy(busy));

  a2d_rr_sched #(.GAP_CYC(0), .BATT_THRESH(THRESH)) u_dut0 (
    .clk(clk), .rst(rst), .nxt(nxt0), .wrt(wrt0), .cmd(cmd0), .done(done0), .rd_data(rd_data0),
    .lft_ld(lft0), .rght_ld(rght0), .batt(batt0), .cnv_cmplt(cnv0),
`ifdef BATT_LOW_EN
    .batt_low(batt_low0),
`endif
    .busy(busy0));

  typedef struct { int cyc; logic [15:0] cmd; } wexp_t;
  typedef struct { int cyc; logic [11:0] l; logic [11:0] r; logic [11:0] b; logic bl; } cexp_t;

  int n_tests = 0, n_fail = 0, cyc = 0;
  wexp_t wq[$];
  cexp_t cq[$];
  logic [11:0] adc [8];
  bit   mon_en = 0, glitch_en = 0, spur_en = 0;
  int   dly_min = 1, dly_max = 4, pending = 0;

  // Reference model state: one conversion in flight at most.
  bit          m_busy = 0, m_bl = 0;
  int          m_ptr = 0, m_phase = 0, m_wcyc = 0;
  logic [11:0] m_res [3] = '{12'h0, 12'h0, 12'h0};
  logic [15:0] m_cmd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] chan(input int p);
    return (p == 0) ? 3'd0 : (p == 1) ? 3'd4 : 3'd5;
  endfunction

  // Model: evaluates the sampled inputs at every edge; cycle N is the period after edge N.
  initial forever begin
    wexp_t we;
    cexp_t ce;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy = 0; m_bl = 0; m_ptr = 0; m_phase = 0;
      m_res = '{12'h0, 12'h0, 12'h0};
      wq.delete(); cq.delete();
    end else if (!m_busy && nxt) begin
      m_busy = 1; m_phase = 1;
      m_cmd  = {2'b00, chan(m_ptr), 11'h000};
      m_wcyc = cyc + 1;
      we.cyc = m_wcyc; we.cmd = m_cmd; wq.push_back(we);
    end else if (m_busy && done && cyc > m_wcyc + 1) begin
      if (m_phase == 1) begin
        m_phase = 2;
        m_wcyc  = cyc + int'(TB_GAP) + 1;
        we.cyc = m_wcyc; we.cmd = m_cmd; wq.push_back(we);
      end else begin
        m_res[m_ptr] = rd_data[11:0];
        if (m_ptr == 2) m_bl = (rd_data[11:0] < THRESH);
        m_ptr  = (m_ptr + 1) % 3;
        m_busy = 0; m_phase = 0;
        ce.cyc = cyc; ce.l = m_res[0]; ce.r = m_res[1]; ce.b = m_res[2]; ce.bl = m_bl;
        cq.push_back(ce);
      end
    end
  end

  // SPI responder: answers each wrt after a random latency, with optional noise pulses.
  initial forever begin
    @(negedge clk);
    done    = 1'b0;
    rd_data = 16'($urandom);
    if (rst) pending = 0;
    else if (wrt) begin
      pending = $urandom_range(dly_max, dly_min);
      if (glitch_en && $urandom_range(0, 3) == 0) done = 1'b1;
    end else if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        done    = 1'b1;
        rd_data = {4'($urandom), adc[cmd[13:11]]};
      end
    end else if (spur_en && $urandom_range(0, 5) == 0) done = 1'b1;
  end

  // Monitor: compares visible state every cycle and pops expected events on wrt/cnv_cmplt.
  initial forever begin
    wexp_t we;
    cexp_t ce;
    @(negedge clk);
    if (mon_en) begin
      chk("busy", busy, m_busy);
      chk("lft_ld", lft_ld, m_res[0]);
      chk("rght_ld", rght_ld, m_res[1]);
      chk("batt", batt, m_res[2]);
`ifdef BATT_LOW_EN
      chk("batt_low", batt_low, m_bl);
`endif
      if (wrt) begin
        if (wq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wrt_unexpected: got wrt=1 at cycle %0d, required none", cyc);
        end else begin
          we = wq.pop_front();
          chk("wrt_cycle", cyc, we.cyc);
          chk("wrt_cmd", cmd, we.cmd);
        end
      end else if (wq.size() > 0 && wq[0].cyc < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL wrt_missing: got no wrt, required one at cycle %0d", wq[0].cyc);
        void'(wq.pop_front());
      end
      if (cnv_cmplt) begin
        if (cq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cnv_unexpected: got cnv_cmplt=1 at cycle %0d, required none", cyc);
        end else begin
          ce = cq.pop_front();
          chk("cnv_cycle", cyc, ce.cyc);
          chk("cnv_res", {lft_ld, rght_ld, batt}, {ce.l, ce.r, ce.b});
        end
      end else if (cq.size() > 0 && cq[0].cyc < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL cnv_missing: got no cnv_cmplt, required one at cycle %0d", cq[0].cyc);
        void'(cq.pop_front());
      end
    end
  end

  task automatic pulse_nxt();
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
  endtask

  task automatic wait_quiet();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!m_busy && !busy && wq.size() == 0 && cq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_quiet: got busy=%0b after 300 clks, required idle", busy);
    end
  endtask

  task automatic conv();
    pulse_nxt();
    wait_quiet();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1; nxt = 1'b0; nxt0 = 1'b0; done0 = 1'b0; rd_data0 = 16'h0;
    for (int c = 0; c < 8; c++) adc[c] = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_wrt", wrt, 1'b0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnv", cnv_cmplt, 1'b0);
    chk("rst_res", {lft_ld, rght_ld, batt}, 36'h0);
    mon_en = 1;
    rst = 1'b0;

    // T1: single left conversion
    adc[0] = 12'hC00;
    pulse_nxt();
    chk("t1_cmd", cmd, 16'h0000);
    wait_quiet();
    chk("t1_lft", lft_ld, 12'hC00);

    // T2: full rotation then wrap to left
    do_reset();
    adc[0] = 12'h123; adc[4] = 12'h456; adc[5] = 12'hA00;
    repeat (3) conv();
    chk("t2_lft", lft_ld, 12'h123);
    chk("t2_rght", rght_ld, 12'h456);
    chk("t2_batt", batt, 12'hA00);
    pulse_nxt();
    chk("t2_cmd4", cmd, 16'h0000);
    wait_quiet();

    // T3: nxt noise while busy, with done glitches and stray dones
    glitch_en = 1; spur_en = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) nxt = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 200 && busy; i++) begin
        nxt = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      nxt = 1'b0;
      wait_quiet();
    end
    glitch_en = 0; spur_en = 0;

    // T4: zero-gap instance, directed timing
    @(negedge clk) nxt0 = 1'b1;
    @(negedge clk) nxt0 = 1'b0;
    chk("t4_wrt_early", wrt0, 1'b0);
    chk("t4_busy", busy0, 1'b1);
    @(negedge clk) chk("t4_wrt1", wrt0, 1'b1);
    @(negedge clk) begin chk("t4_wrt1_len", wrt0, 1'b0); done0 = 1'b1; end
    @(negedge clk) begin chk("t4_cmd2_cyc", wrt0, 1'b0); done0 = 1'b0; end
    @(negedge clk) begin chk("t4_wrt2", wrt0, 1'b1); chk("t4_cmd", cmd0, 16'h0000); end
    @(negedge clk) begin chk("t4_wrt2_len", wrt0, 1'b0); done0 = 1'b1; rd_data0 = 16'hF5A5; end
    @(negedge clk) begin
      done0 = 1'b0;
      chk("t4_cnv", cnv0, 1'b1);
      chk("t4_lft", lft0, 12'h5A5);
      chk("t4_idle", busy0, 1'b0);
    end

    // T5: reset while waiting for the second done
    dly_min = 6; dly_max = 6;
    pulse_nxt();
    seen = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      @(negedge clk);
      if (wrt) seen++;
    end
    chk("t5_wrt2_seen", seen, 2);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) begin
      chk("t5_wrt", wrt, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_res", {lft_ld, rght_ld, batt}, 36'h0);
    end
    @(negedge clk) rst = 1'b0;
    pulse_nxt();
    chk("t5_cmd", cmd, 16'h0000);
    wait_quiet();
    dly_min = 1; dly_max = 4;

`ifdef BATT_LOW_EN
    // T6: battery-low threshold edges
    do_reset();
    adc[0] = 12'h111; adc[4] = 12'h222; adc[5] = 12'h7FF;
    repeat (3) conv();
    chk("t6_low", batt_low, 1'b1);
    conv();
    chk("t6_lft_hold", batt_low, 1'b1);
    adc[5] = 12'h800;
    repeat (2) conv();
    chk("t6_ok", batt_low, 1'b0);
`endif

    // Randomized traffic
    glitch_en = 1; spur_en = 1; dly_max = 5;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      nxt = ($urandom_range(0, 5) == 0);
      for (int c = 0; c < 8; c++) adc[c] = 12'($urandom);
      if ($urandom_range(0, 3) == 0) adc[5] = ($urandom_range(0, 1) == 1) ? 12'h7FF : 12'h800;
    end
    nxt = 1'b0; glitch_en = 0; spur_en = 0;
    wait_quiet();
    chk("end_wq_empty", wq.size(), 0);
    chk("end_cq_empty", cq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

endmodule
